// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry result buffer per requester.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   rN_valid/rN_ready              request handshake (N = 0, 1)
//   rN_op, rN_a, rN_b              requested operation and operands
//   rN_rsp_valid/rN_rsp_ready      response handshake
//   rN_rsp_data, rN_rsp_err        buffered result, undefined-opcode flag
//   SrcA, SrcB, Operation          drive the shared ALU
//   ALUResult                      combinational result from the shared ALU
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     r0_valid,
  output logic                     r0_ready,
  input  logic [OPCODE_LENGTH-1:0] r0_op,
  input  logic [DATA_WIDTH-1:0]    r0_a,
  input  logic [DATA_WIDTH-1:0]    r0_b,
  output logic                     r0_rsp_valid,
  input  logic                     r0_rsp_ready,
  output logic [DATA_WIDTH-1:0]    r0_rsp_data,
  output logic                     r0_rsp_err,

  input  logic                     r1_valid,
  output logic                     r1_ready,
  input  logic [OPCODE_LENGTH-1:0] r1_op,
  input  logic [DATA_WIDTH-1:0]    r1_a,
  input  logic [DATA_WIDTH-1:0]    r1_b,
  output logic                     r1_rsp_valid,
  input  logic                     r1_rsp_ready,
  output logic [DATA_WIDTH-1:0]    r1_rsp_data,
  output logic                     r1_rsp_err,

  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    ALUResult
);

  localparam logic [OPCODE_LENGTH-1:0] OP_U0 = OPCODE_LENGTH'(12);
  localparam logic [OPCODE_LENGTH-1:0] OP_U1 = OPCODE_LENGTH'(13);
  localparam logic [OPCODE_LENGTH-1:0] OP_U2 = OPCODE_LENGTH'(14);

  logic                  r_prio;
  logic                  r_v0;
  logic                  r_v1;
  logic [DATA_WIDTH-1:0] r_d0;
  logic [DATA_WIDTH-1:0] r_d1;
  logic                  r_e0;
  logic                  r_e1;

  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_undef;
  logic [DATA_WIDTH-1:0] w_res;

  // A full buffer that drains this cycle frees its slot for a reload.
  assign w_elig0 = r0_valid && (!r_v0 || r0_rsp_ready);
  assign w_elig1 = r1_valid && (!r_v1 || r1_rsp_ready);

  // Grants are gated by rst_n so nothing leaks out while reset is held.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      if (w_elig0 && w_elig1) begin
        w_gnt0 = !r_prio;
        w_gnt1 = r_prio;
      end else begin
        w_gnt0 = w_elig0;
        w_gnt1 = w_elig1;
      end
    end
  end

  assign r0_ready = w_gnt0;
  assign r1_ready = w_gnt1;

  always_comb begin
    SrcA      = '0;
    SrcB      = '0;
    Operation = '0;
    unique case (1'b1)
      w_gnt0: begin
        SrcA      = r0_a;
        SrcB      = r0_b;
        Operation = r0_op;
      end
      w_gnt1: begin
        SrcA      = r1_a;
        SrcB      = r1_b;
        Operation = r1_op;
      end
      default: ;
    endcase
  end

  assign w_undef = (Operation == OP_U0) ||
                   (Operation == OP_U1) ||
                   (Operation == OP_U2);
  assign w_res   = w_undef ? '0 : ALUResult;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_gnt0) begin
      r_prio <= 1'b1;
    end else if (w_gnt1) begin
      r_prio <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0 <= 1'b0;
      r_d0 <= '0;
      r_e0 <= 1'b0;
    end else if (w_gnt0) begin
      r_v0 <= 1'b1;
      r_d0 <= w_res;
      r_e0 <= w_undef;
    end else if (r0_rsp_ready) begin
      r_v0 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
      r_e1 <= 1'b0;
    end else if (w_gnt1) begin
      r_v1 <= 1'b1;
      r_d1 <= w_res;
      r_e1 <= w_undef;
    end else if (r1_rsp_ready) begin
      r_v1 <= 1'b0;
    end
  end

  assign r0_rsp_valid = r_v0;
  assign r0_rsp_data  = r_d0;
  assign r0_rsp_err   = r_e0;
  assign r1_rsp_valid = r_v1;
  assign r1_rsp_data  = r_d1;
  assign r1_rsp_err   = r_e1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: random traffic against a queue-based reference
// model, plus directed single-request, contention, backpressure and reset cases.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
  logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
  logic [3:0]  r0_op, r1_op, Operation;
  logic [31:0] r0_a, r0_b, r1_a, r1_b, r0_rsp_data, r1_rsp_data;
  logic [31:0] SrcA, SrcB, ALUResult;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];
  int   m_prio;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [3:0] op, logic [31:0] a,
                                        logic [31:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return {31'd0, $signed(a) < $signed(b)};
      default: return ~a;
    endcase
  endfunction

  function automatic rsp_t expect_of(logic [3:0] op, logic [31:0] a,
                                     logic [31:0] b);
    rsp_t r;
    if (op >= 4'd12 && op <= 4'd14) begin
      r.d = 32'd0;
      r.e = 1'b1;
    end else begin
      r.d = alu_f(op, a, b);
      r.e = 1'b0;
    end
    return r;
  endfunction

  assign ALUResult = alu_f(Operation, SrcA, SrcB);

  alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
    .r0_a(r0_a), .r0_b(r0_b),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
    .r1_a(r1_a), .r1_b(r1_b),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ALUResult(ALUResult)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Monitor: samples 4 time units after each negedge (1 before posedge).
  always begin
    int   g;
    bit   e0, e1;
    rsp_t r;
    @(negedge clk);
    #4;
    if (!rst_n) begin
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_ready", r1_ready, 0);
      chk("rst_srca", SrcA, 0);
      chk("rst_srcb", SrcB, 0);
      chk("rst_op", Operation, 0);
      chk("rst_r0_rsp_valid", r0_rsp_valid, 0);
      chk("rst_r1_rsp_valid", r1_rsp_valid, 0);
      q0.delete();
      q1.delete();
      m_prio = 0;
    end else begin
      e0 = r0_valid && (q0.size() == 0 || r0_rsp_ready);
      e1 = r1_valid && (q1.size() == 0 || r1_rsp_ready);
      if (e0 && e1) g = m_prio;
      else if (e0)  g = 0;
      else if (e1)  g = 1;
      else          g = -1;
      chk("r0_ready", r0_ready, g == 0);
      chk("r1_ready", r1_ready, g == 1);
      if (g == 0) begin
        chk("srca", SrcA, r0_a);
        chk("srcb", SrcB, r0_b);
        chk("op", Operation, r0_op);
      end else if (g == 1) begin
        chk("srca", SrcA, r1_a);
        chk("srcb", SrcB, r1_b);
        chk("op", Operation, r1_op);
      end else begin
        chk("srca_idle", SrcA, 0);
        chk("srcb_idle", SrcB, 0);
        chk("op_idle", Operation, 0);
      end
      if (q0.size() > 0) begin
        chk("r0_rsp_valid", r0_rsp_valid, 1);
        chk("r0_rsp_data", r0_rsp_data, q0[0].d);
        chk("r0_rsp_err", r0_rsp_err, q0[0].e);
        if (r0_rsp_ready) void'(q0.pop_front());
      end else begin
        chk("r0_rsp_valid", r0_rsp_valid, 0);
      end
      if (q1.size() > 0) begin
        chk("r1_rsp_valid", r1_rsp_valid, 1);
        chk("r1_rsp_data", r1_rsp_data, q1[0].d);
        chk("r1_rsp_err", r1_rsp_err, q1[0].e);
        if (r1_rsp_ready) void'(q1.pop_front());
      end else begin
        chk("r1_rsp_valid", r1_rsp_valid, 0);
      end
      if (g == 0) begin
        r = expect_of(r0_op, r0_a, r0_b);
        q0.push_back(r);
        m_prio = 1;
      end else if (g == 1) begin
        r = expect_of(r1_op, r1_a, r1_b);
        q1.push_back(r);
        m_prio = 0;
      end
    end
  end

  task automatic idle();
    r0_valid = 0; r1_valid = 0;
    r0_rsp_ready = 1; r1_rsp_ready = 1;
    r0_op = 0; r1_op = 0;
    r0_a = 0; r0_b = 0; r1_a = 0; r1_b = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("async_r0_rsp_valid", r0_rsp_valid, 0);
    chk("async_r1_rsp_valid", r1_rsp_valid, 0);
    chk("async_r0_rsp_data", r0_rsp_data, 0);
    chk("async_r1_rsp_err", r1_rsp_err, 0);
    q0.delete();
    q1.delete();
    m_prio = 0;
    @(negedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    m_prio = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1;

    // single request
    @(negedge clk);
    r0_valid = 1; r0_op = 4'b0010; r0_a = 5; r0_b = 7;
    #3 chk("single_ready", r0_ready, 1);
    @(negedge clk);
    idle();
    #3;
    chk("single_rsp_valid", r0_rsp_valid, 1);
    chk("single_rsp_data", r0_rsp_data, 12);
    chk("single_rsp_err", r0_rsp_err, 0);

    // contention from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      r0_valid = 1; r0_op = 4'b0010;
      r0_a = $urandom; r0_b = $urandom;
      r1_valid = 1; r1_op = 4'b0011; r1_a = 3; r1_b = 5;
      #3;
      chk("alt_r0_ready", r0_ready, (i % 2) == 0);
      chk("alt_r1_ready", r1_ready, (i % 2) == 1);
      if (i == 2) chk("alt_r1_data", r1_rsp_data, 32'hFFFFFFFE);
    end
    @(negedge clk);
    idle();

    // backpressure on r0
    @(negedge clk);
    r0_valid = 1; r0_op = 4'b0010; r0_a = 10; r0_b = 1;
    r0_rsp_ready = 0;
    #3 chk("bp_first_grant", r0_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      r0_op = 4'($urandom); r0_a = $urandom; r0_b = $urandom;
      r1_valid = 1; r1_op = 4'($urandom_range(0, 7));
      r1_a = $urandom; r1_b = $urandom;
      #3;
      chk("bp_r0_ready", r0_ready, 0);
      chk("bp_r1_ready", r1_ready, 1);
      chk("bp_r0_hold", r0_rsp_data, 11);
    end

    // drain and reload in the same cycle
    @(negedge clk);
    r1_valid = 0;
    r0_valid = 1; r0_op = 4'b0010; r0_a = 20; r0_b = 22;
    r0_rsp_ready = 1;
    #3;
    chk("reload_ready", r0_ready, 1);
    chk("reload_old", r0_rsp_data, 11);
    @(negedge clk);
    r0_valid = 0; r0_rsp_ready = 0;
    #3;
    chk("reload_valid", r0_rsp_valid, 1);
    chk("reload_new", r0_rsp_data, 42);
    @(negedge clk);
    idle();

    // undefined opcode
    @(negedge clk);
    r1_valid = 1; r1_op = 4'b1101; r1_a = 1; r1_b = 1;
    @(negedge clk);
    idle();
    #3;
    chk("undef_valid", r1_rsp_valid, 1);
    chk("undef_data", r1_rsp_data, 0);
    chk("undef_err", r1_rsp_err, 1);

    // fill both buffers, then reset mid-operation
    @(negedge clk);
    r0_valid = 1; r1_valid = 1; r0_op = 4'd4; r1_op = 4'd1;
    r0_a = $urandom; r0_b = $urandom; r1_a = $urandom; r1_b = $urandom;
    r0_rsp_ready = 0; r1_rsp_ready = 0;
    repeat (2) @(negedge clk);
    r0_valid = 0; r1_valid = 0;
    #3;
    chk("full_r0", r0_rsp_valid, 1);
    chk("full_r1", r1_rsp_valid, 1);
    do_reset();
    @(negedge clk);
    r0_valid = 1; r1_valid = 1; r0_rsp_ready = 1; r1_rsp_ready = 1;
    #3;
    chk("post_rst_r0", r0_ready, 1);
    chk("post_rst_r1", r1_ready, 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      r0_valid = $urandom_range(0, 2) != 0;
      r1_valid = $urandom_range(0, 2) != 0;
      r0_rsp_ready = $urandom_range(0, 3) != 0;
      r1_rsp_ready = $urandom_range(0, 3) != 0;
      r0_op = 4'($urandom); r1_op = 4'($urandom);
      r0_a = $urandom; r0_b = $urandom;
      r1_a = $urandom; r1_b = $urandom;
    end
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter OPCODE_LENGTH, default 4, ALU operation code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-006 rN_ready  output  1  requester N granted this cycle; transfer when rN_valid && rN_ready.
REQ-007 rN_op  input  OPCODE_LENGTH  requested ALU operation.
REQ-008 rN_a, rN_b  input  DATA_WIDTH  operands A and B.
REQ-009 rN_rsp_valid  output  1  result buffer N holds a result.
REQ-010 rN_rsp_ready  input  1  requester N accepts result; drain when rN_rsp_valid && rN_rsp_ready.
REQ-011 rN_rsp_data  output  DATA_WIDTH  buffered result.
REQ-012 rN_rsp_err  output  1  buffered result came from an undefined opcode.
REQ-013 SrcA, SrcB  output  DATA_WIDTH  operands to the shared ALU.
REQ-014 Operation  output  OPCODE_LENGTH  operation to the shared ALU.
REQ-015 ALUResult  input  DATA_WIDTH  combinational result from the shared ALU.

Function
REQ-016 Block SHALL share one combinational ALU between two requesters, at most one grant per cycle.
REQ-017 Requester N eligible when rN_valid=1 and (buffer N empty, or buffer N draining this same cycle).
REQ-018 Arbitration SHALL be round-robin: pointer prio (0/1) names the preferred requester; if both eligible, grant prio; if one eligible, grant it.
REQ-019 After any grant, prio SHALL be set to the non-granted requester index; with no grant prio holds.
REQ-020 rN_ready SHALL be high only in the cycle requester N is granted; never asserted when rN_valid=0.
REQ-021 During a grant, SrcA/SrcB/Operation SHALL equal the granted requester's a/b/op combinationally; with no grant they SHALL be all zeros.
REQ-022 On the granting edge, ALUResult SHALL be captured into buffer N and rN_rsp_valid set; latency request-to-response exactly 1 cycle.
REQ-023 Opcodes 4'b1100, 4'b1101, 4'b1110 are undefined: buffer SHALL store data 0 and rN_rsp_err=1; every other opcode stores ALUResult with rN_rsp_err=0.
REQ-024 Buffer N SHALL hold data/err stable while rN_rsp_valid=1 and rN_rsp_ready=0.
REQ-025 Drain without new grant to N: rN_rsp_valid SHALL clear next edge; drain with simultaneous grant to N: buffer reloads, rN_rsp_valid stays 1 (back-to-back throughput 1/cycle per requester when the other is idle).
REQ-026 A requester whose buffer is full and not draining SHALL NOT be granted; the other requester SHALL then be granted if eligible regardless of prio.
REQ-027 Operands/opcode changes while rN_valid=1 and rN_ready=0 SHALL be tolerated; the values present in the grant cycle are used.
REQ-028 Buffers 0 and 1 are independent; a stalled response on one SHALL NOT block the other.

Reset
REQ-029 rst_n low SHALL immediately clear prio to 0, both rN_rsp_valid, rN_rsp_data, rN_rsp_err to 0, independent of clk.
REQ-030 While rst_n low, rN_ready SHALL be 0 and SrcA/SrcB/Operation 0.
REQ-031 Reset asserted mid-operation SHALL discard buffered results; first grant after release follows prio=0.

Verification
REQ-032 Single request: r0 op=4'b0010 a=5 b=7, r1 idle -> r0_ready=1 that cycle, next cycle r0_rsp_valid=1 data=12 err=0.
REQ-033 Contention: both valid every cycle, rsp_ready=1 -> grants alternate r0,r1,r0,r1 from reset; r1 op=4'b0011 a=3 b=5 returns 32'hFFFFFFFE.
REQ-034 Backpressure: r0_rsp_ready=0 after one result, r0 keeps requesting, r1 requesting -> r0_ready stays 0, r1 granted every cycle, r0 data held stable.
REQ-035 Drain/reload: r0 buffer full, r0_rsp_ready=1 and r0_valid=1 same cycle, r1 idle -> r0_ready=1, r0_rsp_valid remains 1 with new data next cycle.
REQ-036 Undefined opcode: r1 op=4'b1101 a=1 b=1 -> r1_rsp_valid=1, data=0, err=1.
REQ-037 Async reset: rst_n pulsed low between edges with both buffers full -> rsp_valid outputs 0 immediately; after release, simultaneous requests grant r0 first.
